core_feeder: RTL and testbench

- Transmit side of the core_top compute input interface.
- Sequences activation/weight beats from an upstream ready/valid stream into the core's i_Act/i_Weight/i_Flush/i_Sel_Bias/i_Bias/core_vld inputs.
- Loop order per layer, outermost first: channel group, then output row, then output column, then beat.
- Each output pixel is framed as one flush-marked first data beat, then data beats, then a closing bias beat.

---
 rtl/core_feeder_pkg.sv | 30 +++
 rtl/core_feeder_cnt.sv | 64 ++++++
 rtl/core_feeder.sv | 139 +++++++++++++
 tb/tb_core_feeder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_feeder_pkg.sv
// Shared widths, state encoding and config helpers for the core_top input feeder.
package core_feeder_pkg;

    localparam int unsigned BITS_ACT    = 8;
    localparam int unsigned BITS_WEIGHT = 8;
    localparam int unsigned PE_ROW      = 32;
    localparam int unsigned N_BIAS      = 32;
    localparam int unsigned PE_ARRAY    = 8;

    localparam int unsigned ACT_BUS_W  = BITS_ACT * PE_ROW * 4;
    localparam int unsigned WGT_BUS_W  = BITS_WEIGHT * PE_ROW * 4;
    localparam int unsigned BIAS_BUS_W = N_BIAS * PE_ARRAY;

    localparam int unsigned GRP_W  = 6;
    localparam int unsigned ROW_W  = 9;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned BEAT_W = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A pixel needs at least the flush data beat and the bias beat.
    function automatic logic [BEAT_W-1:0] clamp_beats(input logic [BEAT_W-1:0] beats);
        return (beats < BEAT_W'(2)) ? BEAT_W'(2) : beats;
    endfunction

endpackage

// File: rtl/core_feeder_cnt.sv
// Nested beat/col/row/grp counter chain; beat is the innermost loop, group the outermost.
module core_feeder_cnt
    import core_feeder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [GRP_W-1:0]  grps_i,
    input  logic [ROW_W-1:0]  rows_i,
    input  logic [COL_W-1:0]  cols_i,
    input  logic [BEAT_W-1:0] beats_i,
    output logic [GRP_W-1:0]  grp_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_beat_o,
    output logic              terminal_o
);

    logic [GRP_W-1:0]  grp_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [BEAT_W-1:0] beat_q;
    logic              last_col, last_row, last_grp;

    assign last_beat_o = (beat_q == beats_i - BEAT_W'(1));
    assign last_col    = (col_q == cols_i - COL_W'(1));
    assign last_row    = (row_q == rows_i - ROW_W'(1));
    assign last_grp    = (grp_q == grps_i - GRP_W'(1));
    assign terminal_o  = last_beat_o && last_col && last_row && last_grp;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            grp_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            beat_q <= '0;
        end else if (advance_i) begin
            if (!last_beat_o) begin
                beat_q <= beat_q + BEAT_W'(1);
            end else begin
                beat_q <= '0;
                if (!last_col) begin
                    col_q <= col_q + COL_W'(1);
                end else begin
                    col_q <= '0;
                    if (!last_row) begin
                        row_q <= row_q + ROW_W'(1);
                    end else begin
                        row_q <= '0;
                        grp_q <= last_grp ? '0 : grp_q + GRP_W'(1);
                    end
                end
            end
        end
    end

    assign grp_o  = grp_q;
    assign row_o  = row_q;
    assign col_o  = col_q;
    assign beat_o = beat_q;

endmodule

// File: rtl/core_feeder.sv
// Feeds activation/weight stream words and per-pixel bias beats into the core_top inputs.
module core_feeder
    import core_feeder_pkg::*;
#(
    parameter int unsigned ACT_W  = ACT_BUS_W,
    parameter int unsigned WGT_W  = WGT_BUS_W,
    parameter int unsigned BIAS_W = BIAS_BUS_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [GRP_W-1:0]  cfg_grps,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [BEAT_W-1:0] cfg_beats,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ACT_W-1:0]  s_act,
    input  logic [WGT_W-1:0]  s_weight,
    input  logic [BIAS_W-1:0] bias_in,
    output logic [ACT_W-1:0]  o_Act,
    output logic [WGT_W-1:0]  o_Weight,
    output logic [BIAS_W-1:0] o_Bias,
    output logic              o_Sel_Bias,
    output logic              o_Flush,
    output logic              core_vld,
    output logic [GRP_W-1:0]  o_grp,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [GRP_W-1:0]  grps_q;
    logic [ROW_W-1:0]  rows_q;
    logic [COL_W-1:0]  cols_q;
    logic [BEAT_W-1:0] beats_q;

    logic [GRP_W-1:0]  grp;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BEAT_W-1:0] beat;
    logic              last_beat, terminal, run, advance;

    assign run     = (state_q == StRun);
    assign busy    = run;
    // The bias beat never consumes a stream word and is never stalled.
    assign s_ready = run && !last_beat;
    assign advance = run && (last_beat || s_valid);

    core_feeder_cnt u_cnt (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clear_i     (!run),
        .advance_i   (advance),
        .grps_i      (grps_q),
        .rows_i      (rows_q),
        .cols_i      (cols_q),
        .beats_i     (beats_q),
        .grp_o       (grp),
        .row_o       (row),
        .col_o       (col),
        .beat_o      (beat),
        .last_beat_o (last_beat),
        .terminal_o  (terminal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            grps_q     <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            beats_q    <= '0;
            core_vld   <= 1'b0;
            o_Act      <= '0;
            o_Weight   <= '0;
            o_Bias     <= '0;
            o_Sel_Bias <= 1'b0;
            o_Flush    <= 1'b0;
            o_grp      <= '0;
            o_row      <= '0;
            o_col      <= '0;
            done       <= 1'b0;
        end else begin
            core_vld   <= 1'b0;
            o_Act      <= '0;
            o_Weight   <= '0;
            o_Bias     <= '0;
            o_Sel_Bias <= 1'b0;
            o_Flush    <= 1'b0;
            o_grp      <= '0;
            o_row      <= '0;
            o_col      <= '0;
            done       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        grps_q  <= cfg_grps;
                        rows_q  <= cfg_rows;
                        cols_q  <= cfg_cols;
                        beats_q <= clamp_beats(cfg_beats);
                        // An empty loop nest skips straight to the done pulse.
                        if (cfg_grps == '0 || cfg_rows == '0 || cfg_cols == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    o_grp <= grp;
                    o_row <= row;
                    o_col <= col;
                    if (last_beat) begin
                        core_vld   <= 1'b1;
                        o_Bias     <= bias_in;
                        o_Sel_Bias <= 1'b1;
                        if (terminal) begin
                            state_q <= StDone;
                        end
                    end else if (s_valid) begin
                        core_vld <= 1'b1;
                        o_Act    <= s_act;
                        o_Weight <= s_weight;
                        o_Flush  <= (beat == '0);
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_core_feeder.sv
// Scoreboard bench for core_feeder: expected beats are queued per layer and popped as core_vld rises.
module tb_core_feeder;
    import core_feeder_pkg::*;

    localparam int unsigned AW = ACT_BUS_W;
    localparam int unsigned WW = WGT_BUS_W;
    localparam int unsigned BW = BIAS_BUS_W;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [GRP_W-1:0]  cfg_grps;
    logic [ROW_W-1:0]  cfg_rows;
    logic [COL_W-1:0]  cfg_cols;
    logic [BEAT_W-1:0] cfg_beats;
    logic              s_valid;
    logic              s_ready;
    logic [AW-1:0]     s_act;
    logic [WW-1:0]     s_weight;
    logic [BW-1:0]     bias_in;
    logic [AW-1:0]     o_Act;
    logic [WW-1:0]     o_Weight;
    logic [BW-1:0]     o_Bias;
    logic              o_Sel_Bias;
    logic              o_Flush;
    logic              core_vld;
    logic [GRP_W-1:0]  o_grp;
    logic [ROW_W-1:0]  o_row;
    logic [COL_W-1:0]  o_col;
    logic              busy;
    logic              done;

    always #5 CLK = ~CLK;

    core_feeder dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .cfg_grps   (cfg_grps),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_beats  (cfg_beats),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_act      (s_act),
        .s_weight   (s_weight),
        .bias_in    (bias_in),
        .o_Act      (o_Act),
        .o_Weight   (o_Weight),
        .o_Bias     (o_Bias),
        .o_Sel_Bias (o_Sel_Bias),
        .o_Flush    (o_Flush),
        .core_vld   (core_vld),
        .o_grp      (o_grp),
        .o_row      (o_row),
        .o_col      (o_col),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [AW-1:0] act;
        logic [WW-1:0] wgt;
        logic [BW-1:0] bias;
        logic [25:0]   meta;  // {flush, sel_bias, grp, row, col}
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [AW-1:0] act_of(input int w);
        logic [31:0] v;
        v = 32'(w) + 32'd5;
        return {(AW / 32){v}};
    endfunction

    function automatic logic [WW-1:0] wgt_of(input int w);
        logic [31:0] v;
        v = 32'h1000_0000 + 32'(w);
        return {(WW / 32){v}};
    endfunction

    function automatic int all_quiet();
        return int'({core_vld, busy, done, s_ready, o_Flush, o_Sel_Bias, |o_Act, |o_Weight,
                     |o_Bias, |o_grp, |o_row, |o_col});
    endfunction

    task automatic run_layer(input int grps, input int rows, input int cols, input int beats,
                             input int stall_at, input int stall_len, input int abort_at,
                             input int restart_at, input logic [BW-1:0] bias_val);
        int    n, w, hs, vld, flushes, sels, bubbles, dones, cyc;
        int    done_cyc, last_vld_cyc, stall_cnt, total_exp, pixels, budget;
        bit    restarted;
        beat_t e;
        n = (beats < 2) ? 2 : beats;
        exp_q.delete();
        w = 0;
        pixels = 0;
        if (grps > 0 && rows > 0 && cols > 0) begin
            for (int g = 0; g < grps; g++)
                for (int r = 0; r < rows; r++)
                    for (int c = 0; c < cols; c++) begin
                        pixels++;
                        for (int bt = 0; bt < n; bt++) begin
                            if (bt < n - 1) begin
                                e.act  = act_of(w);
                                e.wgt  = wgt_of(w);
                                e.bias = '0;
                                e.meta = {(bt == 0), 1'b0, 6'(g), 9'(r), 9'(c)};
                                w++;
                            end else begin
                                e.act  = '0;
                                e.wgt  = '0;
                                e.bias = bias_val;
                                e.meta = {1'b0, 1'b1, 6'(g), 9'(r), 9'(c)};
                            end
                            exp_q.push_back(e);
                        end
                    end
        end
        total_exp = exp_q.size();
        budget = total_exp + stall_len + 20;
        w = 0; hs = 0; vld = 0; flushes = 0; sels = 0; bubbles = 0; dones = 0;
        done_cyc = -1; last_vld_cyc = -1; stall_cnt = 0; restarted = 1'b0; cyc = 0;

        bias_in   = bias_val;
        cfg_grps  = GRP_W'(grps);
        cfg_rows  = ROW_W'(rows);
        cfg_cols  = COL_W'(cols);
        cfg_beats = BEAT_W'(beats);
        start     = 1'b1;

        while (cyc < budget && !(dones > 0 && cyc >= done_cyc + 3)) begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk_int("busy_after_start", int'(busy), int'(total_exp > 0));
            if (core_vld) begin
                vld++;
                last_vld_cyc = cyc;
                flushes += int'(o_Flush);
                sels    += int'(o_Sel_Bias);
                if (exp_q.size() == 0) begin
                    chk_int("extra_beat", vld, total_exp);
                end else begin
                    e = exp_q.pop_front();
                    chk_bus("beat_act", 1024'(o_Act), 1024'(e.act));
                    chk_bus("beat_weight", 1024'(o_Weight), 1024'(e.wgt));
                    chk_bus("beat_bias", 1024'(o_Bias), 1024'(e.bias));
                    chk_int("beat_flags_idx", int'({o_Flush, o_Sel_Bias, o_grp, o_row, o_col}),
                            int'(e.meta));
                end
            end else begin
                if (vld > 0 && vld < total_exp) bubbles++;
                chk_int("idle_bus_zero", int'({o_Flush, o_Sel_Bias, |o_Act, |o_Weight, |o_Bias}), 0);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (abort_at > 0 && vld == abort_at) begin
                RST     = 1'b1;
                s_valid = 1'b0;
                @(negedge CLK);
                RST = 1'b0;
                chk_int("abort_outputs_zero", all_quiet(), 0);
                for (int i = 0; i < 6; i++) begin
                    @(negedge CLK);
                    dones += int'(done);
                    bubbles += int'(core_vld);
                end
                chk_int("abort_no_done", dones, 0);
                chk_int("abort_stays_quiet", bubbles, 0);
                exp_q.delete();
                return;
            end
            if (restart_at > 0 && vld == restart_at && !restarted) begin
                restarted = 1'b1;
                start     = 1'b1;
                cfg_grps  = GRP_W'(1);
                cfg_rows  = ROW_W'(1);
                cfg_cols  = COL_W'(1);
                cfg_beats = BEAT_W'(3);
            end
            if (stall_len > 0 && w == stall_at && stall_cnt < stall_len) begin
                s_valid = 1'b0;
                stall_cnt++;
            end else begin
                s_valid  = 1'b1;
                s_act    = act_of(w);
                s_weight = wgt_of(w);
                if (s_ready) begin
                    w++;
                    hs++;
                end
            end
        end
        s_valid = 1'b0;

        chk_int("done_pulses", dones, 1);
        chk_int("vld_beats", vld, total_exp);
        chk_int("handshakes", hs, pixels * (n - 1));
        chk_int("flush_count", flushes, pixels);
        chk_int("sel_bias_count", sels, pixels);
        chk_int("queue_drained", exp_q.size(), 0);
        chk_int("bubble_cycles", bubbles, stall_len);
        if (total_exp > 0) chk_int("done_after_last", done_cyc, last_vld_cyc + 1);
        else chk_int("done_degenerate", done_cyc, 2);
    endtask

    initial begin
        RST       = 1'b1;
        start     = 1'b0;
        cfg_grps  = '0;
        cfg_rows  = '0;
        cfg_cols  = '0;
        cfg_beats = '0;
        s_valid   = 1'b0;
        s_act     = '0;
        s_weight  = '0;
        bias_in   = '0;
        repeat (3) @(negedge CLK);
        chk_int("reset_outputs", all_quiet(), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk_int("idle_outputs", all_quiet(), 0);

        // basic pixel
        run_layer(1, 1, 1, 4, 0, 0, 0, 0, {8{32'hB1A5_0001}});
        // loop order over 12 pixels
        run_layer(2, 2, 3, 144, 0, 0, 0, 0, {8{32'hB1A5_0002}});
        // stall on beats 5..7
        run_layer(1, 1, 2, 10, 5, 3, 0, 0, {8{32'hB1A5_0003}});
        // degenerate: zero columns, then clamped beat counts
        run_layer(1, 1, 0, 4, 0, 0, 0, 0, {8{32'hB1A5_0004}});
        run_layer(1, 1, 1, 1, 0, 0, 0, 0, {8{32'hB1A5_0005}});
        run_layer(1, 2, 1, 0, 0, 0, 0, 0, {8{32'hB1A5_0006}});
        // reset mid-layer at pixel 3 beat 50, then a fresh full layer
        run_layer(1, 2, 3, 144, 0, 0, 3 * 144 + 50, 0, {8{32'hB1A5_0007}});
        run_layer(1, 2, 3, 144, 0, 0, 0, 0, {8{32'hB1A5_0008}});
        // start pulse while busy is ignored
        run_layer(1, 1, 3, 20, 0, 0, 0, 10, {8{32'hB1A5_0009}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
